// File: rtl/multi_port_cam_regfile_pkg.sv
// Shared sizing helpers for the multi-port CAM register file.
package multi_port_cam_regfile_pkg;

  localparam int unsigned DEF_ENTRY_WIDTH    = 8;
  localparam int unsigned DEF_NUM_ENTRY      = 4;
  localparam int unsigned DEF_NUM_READ_PORT  = 2;

  function automatic int unsigned index_width(input int unsigned num_entry);
    return (num_entry < 2) ? 1 : $clog2(num_entry);
  endfunction

  // LSB of port `port` inside a flat vector packed `width` bits per port.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/multi_port_cam_regfile_if.sv
// Read/write/invalidate/CAM bus of the multi-port CAM register file.
interface multi_port_cam_regfile_if
  import multi_port_cam_regfile_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = DEF_ENTRY_WIDTH,
  parameter int unsigned NUM_ENTRY                  = DEF_NUM_ENTRY,
  parameter int unsigned NUM_READ_PORT              = DEF_NUM_READ_PORT
);
  localparam int unsigned W     = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned IDX_W = index_width(NUM_ENTRY);

  logic [NUM_READ_PORT-1:0]           read_en_in;
  logic [NUM_READ_PORT*NUM_ENTRY-1:0] read_entry_addr_decoded_in;
  logic [NUM_READ_PORT*W-1:0]         read_entry_out;
  logic [NUM_READ_PORT-1:0]           read_valid_out;
  logic                               write_en_in;
  logic [NUM_ENTRY-1:0]               write_entry_addr_decoded_in;
  logic [W-1:0]                       write_entry_in;
  logic                               invalidate_en_in;
  logic [NUM_ENTRY-1:0]               invalidate_entry_addr_decoded_in;
  logic                               cam_en_in;
  logic [W-1:0]                       cam_entry_in;
  logic [W-1:0]                       cam_mask_in;
  logic [NUM_ENTRY-1:0]               cam_result_decoded_out;
  logic                               cam_hit_out;
  logic [IDX_W-1:0]                   cam_hit_index_out;
  logic [NUM_ENTRY-1:0]               entry_valid_out;

  modport master (
    output read_en_in, read_entry_addr_decoded_in, write_en_in, write_entry_addr_decoded_in,
           write_entry_in, invalidate_en_in, invalidate_entry_addr_decoded_in,
           cam_en_in, cam_entry_in, cam_mask_in,
    input  read_entry_out, read_valid_out, cam_result_decoded_out, cam_hit_out,
           cam_hit_index_out, entry_valid_out
  );

  modport slave (
    input  read_en_in, read_entry_addr_decoded_in, write_en_in, write_entry_addr_decoded_in,
           write_entry_in, invalidate_en_in, invalidate_entry_addr_decoded_in,
           cam_en_in, cam_entry_in, cam_mask_in,
    output read_entry_out, read_valid_out, cam_result_decoded_out, cam_hit_out,
           cam_hit_index_out, entry_valid_out
  );
endinterface

// File: rtl/multi_port_cam_regfile_entry.sv
// One storage entry: data + valid flops, write-over-invalidate priority, masked compare.
module regfile_cam_entry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             write_en_in,
  input  logic             invalidate_en_in,
  input  logic [WIDTH-1:0] write_data_in,
  input  logic [WIDTH-1:0] cam_key_in,
  input  logic [WIDTH-1:0] cam_mask_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             match_out
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (write_en_in) begin
      data_d  = write_data_in;
      valid_d = 1'b1;
    end else if (invalidate_en_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Compare against current (pre-update) state.
  assign match_out = valid_q & (((data_q ^ cam_key_in) & cam_mask_in) == '0);
  assign data_out  = data_q;
  assign valid_out = valid_q;
endmodule

// File: rtl/multi_port_cam_regfile.sv
// Multi-read-port register file with masked CAM search, valid bits and optional write bypass.
module multi_port_cam_regfile
  import multi_port_cam_regfile_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = DEF_ENTRY_WIDTH,
  parameter int unsigned NUM_ENTRY                  = DEF_NUM_ENTRY,
  parameter int unsigned NUM_READ_PORT              = DEF_NUM_READ_PORT,
  parameter int unsigned WRITE_BYPASS               = 1
) (
  input logic                     clk_in,
  input logic                     reset_in,
  multi_port_cam_regfile_if.slave bus
);
  localparam int unsigned W     = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned N     = NUM_ENTRY;
  localparam int unsigned P     = NUM_READ_PORT;
  localparam int unsigned IDX_W = index_width(N);

  logic [N-1:0][W-1:0] entry_data;
  logic [N-1:0]        entry_valid, entry_match, write_sel, inval_sel;
  logic [N-1:0][W-1:0] src_data;
  logic [N-1:0]        src_valid;
  logic [N-1:0]        rd_sel;

  logic [P-1:0][W-1:0] read_data_q, read_data_d;
  logic [P-1:0]        read_valid_q, read_valid_d;
  logic [N-1:0]        cam_result_q, cam_result_d;
  logic                cam_hit_q, cam_hit_d;
  logic [IDX_W-1:0]    cam_idx_q, cam_idx_d, match_idx;

  assign write_sel = {N{bus.write_en_in}} & bus.write_entry_addr_decoded_in;
  assign inval_sel = {N{bus.invalidate_en_in}} & bus.invalidate_entry_addr_decoded_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    regfile_cam_entry #(.WIDTH(W)) u_entry (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .write_en_in      (write_sel[gi]),
      .invalidate_en_in (inval_sel[gi]),
      .write_data_in    (bus.write_entry_in),
      .cam_key_in       (bus.cam_entry_in),
      .cam_mask_in      (bus.cam_mask_in),
      .data_out         (entry_data[gi]),
      .valid_out        (entry_valid[gi]),
      .match_out        (entry_match[gi])
    );
  end

  always_comb begin
    src_data  = entry_data;
    src_valid = entry_valid;
    if (WRITE_BYPASS != 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (write_sel[i]) begin
          src_data[i]  = bus.write_entry_in;
          src_valid[i] = 1'b1;
        end
      end
    end
  end

  // Multi-hot read: OR of data, AND of valid; zero-hot yields 0/0.
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = read_valid_q;
    rd_sel       = '0;
    for (int unsigned p = 0; p < P; p++) begin
      if (bus.read_en_in[p]) begin
        rd_sel          = bus.read_entry_addr_decoded_in[port_lsb(p, N) +: N];
        read_data_d[p]  = '0;
        read_valid_d[p] = |rd_sel;
        for (int unsigned i = 0; i < N; i++) begin
          if (rd_sel[i]) begin
            read_data_d[p]  = read_data_d[p] | src_data[i];
            read_valid_d[p] = read_valid_d[p] & src_valid[i];
          end
        end
      end
    end
  end

  always_comb begin
    match_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (entry_match[N-1-i]) match_idx = IDX_W'(N-1-i);
    end
    cam_result_d = cam_result_q;
    cam_hit_d    = cam_hit_q;
    cam_idx_d    = cam_idx_q;
    if (bus.cam_en_in) begin
      cam_result_d = entry_match;
      cam_hit_d    = |entry_match;
      cam_idx_d    = match_idx;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      read_data_q  <= '0;
      read_valid_q <= '0;
      cam_result_q <= '0;
      cam_hit_q    <= 1'b0;
      cam_idx_q    <= '0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      cam_result_q <= cam_result_d;
      cam_hit_q    <= cam_hit_d;
      cam_idx_q    <= cam_idx_d;
    end
  end

  assign bus.read_entry_out         = read_data_q;
  assign bus.read_valid_out         = read_valid_q;
  assign bus.cam_result_decoded_out = cam_result_q;
  assign bus.cam_hit_out            = cam_hit_q;
  assign bus.cam_hit_index_out      = cam_idx_q;
  assign bus.entry_valid_out        = entry_valid;
endmodule

// File: tb/tb_multi_port_cam_regfile.sv
// Bench: bypass and non-bypass instances share stimulus; checked against a behavioural model.
module tb_multi_port_cam_regfile;
  logic clk_in;
  logic reset_in;

  int unsigned checks;
  int unsigned failures;

  logic [1:0] t_read_en;
  logic [7:0] t_read_addr;
  logic       t_write_en;
  logic [3:0] t_write_addr;
  logic [7:0] t_write_data;
  logic       t_inv_en;
  logic [3:0] t_inv_addr;
  logic       t_cam_en;
  logic [7:0] t_cam_key;
  logic [7:0] t_cam_mask;

  multi_port_cam_regfile_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2)) bus_a ();
  multi_port_cam_regfile_if #(.SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2)) bus_b ();

  assign bus_a.read_en_in                       = t_read_en;
  assign bus_a.read_entry_addr_decoded_in       = t_read_addr;
  assign bus_a.write_en_in                      = t_write_en;
  assign bus_a.write_entry_addr_decoded_in      = t_write_addr;
  assign bus_a.write_entry_in                   = t_write_data;
  assign bus_a.invalidate_en_in                 = t_inv_en;
  assign bus_a.invalidate_entry_addr_decoded_in = t_inv_addr;
  assign bus_a.cam_en_in                        = t_cam_en;
  assign bus_a.cam_entry_in                     = t_cam_key;
  assign bus_a.cam_mask_in                      = t_cam_mask;
  assign bus_b.read_en_in                       = t_read_en;
  assign bus_b.read_entry_addr_decoded_in       = t_read_addr;
  assign bus_b.write_en_in                      = t_write_en;
  assign bus_b.write_entry_addr_decoded_in      = t_write_addr;
  assign bus_b.write_entry_in                   = t_write_data;
  assign bus_b.invalidate_en_in                 = t_inv_en;
  assign bus_b.invalidate_entry_addr_decoded_in = t_inv_addr;
  assign bus_b.cam_en_in                        = t_cam_en;
  assign bus_b.cam_entry_in                     = t_cam_key;
  assign bus_b.cam_mask_in                      = t_cam_mask;

  multi_port_cam_regfile #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2), .WRITE_BYPASS(1)
  ) dut_byp (.clk_in(clk_in), .reset_in(reset_in), .bus(bus_a));

  multi_port_cam_regfile #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(8), .NUM_ENTRY(4), .NUM_READ_PORT(2), .WRITE_BYPASS(0)
  ) dut_nob (.clk_in(clk_in), .reset_in(reset_in), .bus(bus_b));

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Reference model: storage arrays plus expected registered outputs (index 0 = bypass DUT).
  logic [7:0] m_data [4];
  logic       m_valid [4];
  logic [7:0] e_rd [2][2];
  logic       e_rv [2][2];
  logic [3:0] e_cam;
  logic       e_hit;
  logic [1:0] e_idx;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        e_rd[d][p] = 8'h00;
        e_rv[d][p] = 1'b0;
      end
    end
    e_cam = 4'b0000;
    e_hit = 1'b0;
    e_idx = 2'd0;
  endtask

  task automatic model_step();
    logic [3:0] sel;
    logic [7:0] acc;
    logic       vacc;
    logic [7:0] val;
    logic       vbit;
    logic       written;
    if (t_cam_en) begin
      e_cam = 4'b0000;
      for (int i = 0; i < 4; i++)
        e_cam[i] = m_valid[i] && ((m_data[i] & t_cam_mask) == (t_cam_key & t_cam_mask));
      e_hit = (e_cam != 4'b0000);
      e_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
        if (e_cam[i]) e_idx = 2'(i);
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (t_read_en[p]) begin
          sel  = t_read_addr[p*4 +: 4];
          acc  = 8'h00;
          vacc = (sel != 4'b0000);
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
              written = t_write_en && t_write_addr[i] && (d == 0);
              val  = written ? t_write_data : m_data[i];
              vbit = written ? 1'b1 : m_valid[i];
              acc  = acc | val;
              vacc = vacc && vbit;
            end
          end
          e_rd[d][p] = acc;
          e_rv[d][p] = vacc;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (t_write_en && t_write_addr[i]) begin
        m_data[i]  = t_write_data;
        m_valid[i] = 1'b1;
      end else if (t_inv_en && t_inv_addr[i]) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [3:0] model_valid_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic check_all();
    for (int p = 0; p < 2; p++) begin
      check_val($sformatf("byp_rd%0d", p),  bus_a.read_entry_out[p*8 +: 8], e_rd[0][p]);
      check_val($sformatf("byp_rv%0d", p),  bus_a.read_valid_out[p],       e_rv[0][p]);
      check_val($sformatf("nob_rd%0d", p),  bus_b.read_entry_out[p*8 +: 8], e_rd[1][p]);
      check_val($sformatf("nob_rv%0d", p),  bus_b.read_valid_out[p],       e_rv[1][p]);
    end
    check_val("byp_cam",   bus_a.cam_result_decoded_out, e_cam);
    check_val("byp_hit",   bus_a.cam_hit_out,            e_hit);
    check_val("byp_idx",   bus_a.cam_hit_index_out,      e_idx);
    check_val("byp_valid", bus_a.entry_valid_out,        model_valid_vec());
    check_val("nob_cam",   bus_b.cam_result_decoded_out, e_cam);
    check_val("nob_hit",   bus_b.cam_hit_out,            e_hit);
    check_val("nob_idx",   bus_b.cam_hit_index_out,      e_idx);
    check_val("nob_valid", bus_b.entry_valid_out,        model_valid_vec());
  endtask

  task automatic clear_inputs();
    t_read_en    = 2'b00;
    t_read_addr  = 8'h00;
    t_write_en   = 1'b0;
    t_write_addr = 4'b0000;
    t_write_data = 8'h00;
    t_inv_en     = 1'b0;
    t_inv_addr   = 4'b0000;
    t_cam_en     = 1'b0;
    t_cam_key    = 8'h00;
    t_cam_mask   = 8'h00;
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
    clear_inputs();
    t_write_en = 1'b1; t_write_addr = addr; t_write_data = data;
  endtask

  task automatic do_cam(input logic [7:0] key, input logic [7:0] mask);
    clear_inputs();
    t_cam_en = 1'b1; t_cam_key = key; t_cam_mask = mask;
  endtask

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 3))
      0: return 8'hF0;
      1: return 8'h0F;
      2: return 8'h3C;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] pick_read_addr();
    case ($urandom_range(0, 7))
      0: return 4'b0000;
      1: return 4'($urandom);
      default: return 4'b0001 << $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    model_reset();
    reset_in = 1'b0;
    #12;
    check_all();
    reset_in = 1'b1;
    #2;

    // Search of an empty store.
    do_cam(8'hF0, 8'hFF);
    cycle();
    check_val("empty_cam", bus_a.cam_result_decoded_out, 4'b0000);
    check_val("empty_hit", bus_a.cam_hit_out, 0);

    do_write(4'b0001, 8'hF0);
    cycle();
    clear_inputs();
    t_read_en = 2'b11; t_read_addr = 8'h01;
    cycle();
    check_val("rd0_f0",   bus_a.read_entry_out[7:0], 8'hF0);
    check_val("rv0_set",  bus_a.read_valid_out[0], 1);
    check_val("rd1_zero", bus_a.read_entry_out[15:8], 8'h00);
    check_val("rv1_zero", bus_a.read_valid_out[1], 0);

    do_write(4'b1111, 8'hF0);
    cycle();
    do_cam(8'hF0, 8'hFF);
    cycle();
    check_val("bcast_cam", bus_a.cam_result_decoded_out, 4'b1111);
    check_val("bcast_idx", bus_a.cam_hit_index_out, 0);

    // Same-cycle write and read of entry 1 (old value F0).
    do_write(4'b0010, 8'h0F);
    t_read_en = 2'b11; t_read_addr = 8'h22;
    cycle();
    check_val("bypass_new",  bus_a.read_entry_out[7:0], 8'h0F);
    check_val("nobypass_old", bus_b.read_entry_out[15:8], 8'hF0);

    do_write(4'b1010, 8'h0F);
    cycle();
    do_cam(8'hF0, 8'hFF);
    cycle();
    check_val("cam_f0", bus_a.cam_result_decoded_out, 4'b0101);
    do_cam(8'h00, 8'hF0);
    cycle();
    check_val("cam_mask_res", bus_a.cam_result_decoded_out, 4'b1010);
    check_val("cam_mask_idx", bus_a.cam_hit_index_out, 1);

    do_write(4'b0001, 8'hF0);
    t_inv_en = 1'b1; t_inv_addr = 4'b0001;
    cycle();
    check_val("wr_beats_inv", bus_a.entry_valid_out[0], 1);
    clear_inputs();
    t_inv_en = 1'b1; t_inv_addr = 4'b0100;
    cycle();
    check_val("inv_valid", bus_a.entry_valid_out, 4'b1011);
    do_cam(8'hF0, 8'hFF);
    cycle();
    check_val("inv_cam", bus_a.cam_result_decoded_out, 4'b0001);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      t_read_en    = 2'($urandom);
      t_read_addr  = {pick_read_addr(), pick_read_addr()};
      t_write_en   = ($urandom_range(0, 2) == 0);
      t_write_addr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      t_write_data = pick_data();
      t_inv_en     = ($urandom_range(0, 3) == 0);
      t_inv_addr   = 4'($urandom);
      t_cam_en     = ($urandom_range(0, 3) != 0);
      t_cam_key    = pick_data();
      t_cam_mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cycle();
    end

    // Asynchronous reset asserted between edges while a write is pending.
    do_write(4'b1111, 8'hAA);
    t_read_en = 2'b11; t_read_addr = 8'h11;
    #2;
    reset_in = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst_valid", bus_a.entry_valid_out, 4'b0000);
    #1;
    reset_in = 1'b1;
    do_cam(8'($urandom), 8'h00);
    cycle();
    check_val("post_rst_cam", bus_a.cam_result_decoded_out, 4'b0000);
    check_val("post_rst_hit", bus_b.cam_hit_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_port_cam_regfile.md
# multi_port_cam_regfile

Parametrised successor of the three-port register file: one write port, NUM_READ_PORT independent registered read ports, one masked CAM search port, per-entry valid bits with an invalidate port, and optional write-to-read bypass. Used as the tag/ID store for small fully-associative structures (store buffers, MSHR tag arrays, rename-free lists). Decoded (one-hot) addressing throughout; all outputs are registered.

## Interface
- SINGLE_ENTRY_WIDTH_IN_BITS, 8, data/tag width per entry
- NUM_ENTRY, 4, entries (≥2)
- NUM_READ_PORT, 2, read ports (≥1)
- WRITE_BYPASS, 1, 1: same-cycle write to a read entry returns new data; 0: returns old data
- clk_in  in  1  single clock, posedge
- reset_in  in  1  asynchronous, active-low reset
- read_en_in  in  NUM_READ_PORT  per-port read enable
- read_entry_addr_decoded_in  in  NUM_READ_PORT*NUM_ENTRY  per-port one-hot address, port p at [p*NUM_ENTRY +: NUM_ENTRY]
- read_entry_out  out  NUM_READ_PORT*SINGLE_ENTRY_WIDTH_IN_BITS  per-port data, same packing
- read_valid_out  out  NUM_READ_PORT  valid bit of the entry read
- write_en_in  in  1  write enable
- write_entry_addr_decoded_in  in  NUM_ENTRY  write mask; multi-hot broadcasts
- write_entry_in  in  SINGLE_ENTRY_WIDTH_IN_BITS  write data
- invalidate_en_in  in  1  invalidate enable
- invalidate_entry_addr_decoded_in  in  NUM_ENTRY  entries to clear valid
- cam_en_in  in  1  search enable
- cam_entry_in  in  SINGLE_ENTRY_WIDTH_IN_BITS  search key
- cam_mask_in  in  SINGLE_ENTRY_WIDTH_IN_BITS  1 = bit compared, 0 = don't care
- cam_result_decoded_out  out  NUM_ENTRY  per-entry match vector
- cam_hit_out  out  1  any match
- cam_hit_index_out  out  $clog2(NUM_ENTRY)  binary index of lowest matching entry
- entry_valid_out  out  NUM_ENTRY  current valid bits (registered state)

## Operation
- Reset (reset_in low, asynchronous): all data, valid bits, and every output go to 0 immediately; held while low.
- Write: write_en_in at posedge loads write_entry_in into every entry whose mask bit is 1 and sets valid.
- Invalidate: invalidate_en_in clears valid of masked entries; data unchanged.
- Write and invalidate on same entry, same cycle: write wins (valid = 1, new data).
- Read port p, read_en_in[p]=1: data of addressed entry and its valid bit are registered to outputs. read_en_in[p]=0: outputs of port p hold their last values.
- Zero-hot read address: data 0, valid 0. Multi-hot read address is illegal; defined result: bitwise OR of selected data, AND of selected valid bits.
- Bypass: read of an entry being written the same cycle returns write_entry_in with valid 1 when WRITE_BYPASS=1; pre-write data and valid when 0. Invalidate is never bypassed (read sees pre-invalidate valid).
- CAM: cam_en_in=1 registers match[i] = valid[i] & (((entry[i] ^ cam_entry_in) & cam_mask_in) == 0). Searches pre-write, pre-invalidate state. cam_en_in=0: CAM outputs hold. All-zero mask matches every valid entry.
- cam_hit_out = |match; cam_hit_index_out = lowest set index, 0 on no hit.

## Timing
- Latency 1: inputs sampled at posedge N, outputs valid after N, stable until posedge N+1.
- Written data visible to a non-bypassed read or CAM issued at N+1.
- All read ports and CAM operate concurrently, no stalls, no back-pressure.
- Reset deassertion mid-sequence: first posedge after release operates normally.

## Structure
- Shared package: entry-width/index-width localparams, $clog2-based index width function, packed-port slice helper.
- Sub-module regfile_cam_entry: one entry's data and valid flops, write/invalidate priority, masked compare; top instantiates NUM_ENTRY copies plus read muxes, priority encoder, and output registers.

## Test plan
- Reset then write 8'hF0 to 4'b0001, read on port 0 -> read_entry_out[7:0]=8'hF0, read_valid_out[0]=1 one cycle later; port 1 zero-hot read -> 0, valid 0.
- Write 8'h0F to 4'b0010 while both ports read 4'b0010 (old 8'hF0 valid) -> WRITE_BYPASS=1: 8'h0F; rerun with WRITE_BYPASS=0: 8'hF0.
- After reset CAM key 8'hF0 mask 8'hFF -> result 4'b0000, hit 0, index 0; broadcast 8'hF0 to 4'b1111, search -> 4'b1111, hit 1, index 0.
- Write 8'h0F to 4'b1010, search 8'hF0 -> 4'b0101, index 0; search key 8'h00 mask 8'hF0 -> 4'b1010, index 1.
- Invalidate 4'b0001 and write 4'b0001 same cycle -> entry valid; invalidate 4'b0100 alone -> entry_valid_out 4'b1011, CAM 8'hF0 -> 4'b0001.
- Assert reset_in low mid-write between edges -> all outputs 0 immediately; after release CAM any key mask 8'h00 -> 4'b0000.
